// File: rtl/fst_pkg.sv
// Shared types and constants for the core's I/O port peripherals.
package fst_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible on dout while not empty.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;

  // A push while full is still taken when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_uart_tx.sv
// Output-port consumer: queues core words and sends each as two 8N1 frames,
// high byte first; reports drain-after-halt and sticky overflow.
module out_uart_tx
  import fst_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_en,
  input  logic [DATA_W-1:0] out_dat,
  input  logic              is_halt,
  output logic              tx,
  output logic              fifo_full,
  output logic              busy,
  output logic              drained,
  output logic              overflow
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  uart_state_t       state_reg;
  uart_state_t       state_next;
  logic [BAUD_W-1:0] baud_reg;
  logic [2:0]        bit_reg;
  logic              byte_sel_reg;
  logic [7:0]        shift_reg;
  logic [7:0]        low_byte_reg;
  logic              overflow_reg;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;
  logic              bit_done;

  assign pop      = (state_reg == IDLE) && !fifo_empty;
  assign bit_done = (baud_reg == BAUD_W'(CLK_DIV - 1));

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_en),
    .pop   (pop),
    .din   (out_dat),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (!fifo_empty) state_next = START;
      START: if (bit_done) state_next = DATA;
      DATA:  if (bit_done && bit_reg == 3'd7) state_next = STOP;
      STOP:  if (bit_done) state_next = byte_sel_reg ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // tx is decoded from registered state so an async reset returns it high at once.
  always_comb begin
    tx = 1'b1;
    case (state_reg)
      START:   tx = 1'b0;
      DATA:    tx = shift_reg[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_reg     <= '0;
      bit_reg      <= '0;
      byte_sel_reg <= 1'b0;
      shift_reg    <= '0;
      low_byte_reg <= '0;
    end else begin
      if (state_reg == IDLE || bit_done) begin
        baud_reg <= '0;
      end else begin
        baud_reg <= baud_reg + 1'b1;
      end

      if (state_reg != DATA) begin
        bit_reg <= '0;
      end else if (bit_done) begin
        bit_reg <= bit_reg + 1'b1;
      end

      if (pop) begin
        shift_reg    <= fifo_dout[15:8];
        low_byte_reg <= fifo_dout[7:0];
        byte_sel_reg <= 1'b0;
      end else if (state_reg == DATA && bit_done) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
      end else if (state_reg == STOP && bit_done && !byte_sel_reg) begin
        shift_reg    <= low_byte_reg;
        byte_sel_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (out_en && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;
  assign busy     = (fifo_count != '0) || (state_reg != IDLE);
  assign drained  = is_halt && !busy;

endmodule
